// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: per-phase programmable countdown sequencer driven by a 1 Hz tick; optional skip input under PHASE_SKIP_EN
module traffic_phase_timer #(
  parameter int W   = 6,
  parameter int NPH = 4,
  parameter int PW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic             restart,
  input  logic             hold,
`ifdef PHASE_SKIP_EN
  input  logic             skip,
`endif
  input  logic [NPH*W-1:0] dur_tbl,
  output logic [PW-1:0]    phase,
  output logic [W-1:0]     sec_count,
  output logic             timeout,
  output logic             cycle_done,
  output logic             running
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, next_ph;
  logic [W-1:0]  sec_q, sec_d;
  logic          timeout_q, timeout_d;
  logic          cycle_done_q, cycle_done_d;
  logic          running_q, running_d;
  logic          last_ph, end_ph, skip_req;
`ifdef PHASE_SKIP_EN
  assign skip_req = skip;
`else
  assign skip_req = 1'b0;
`endif
  assign last_ph = phase_q == PW'(NPH - 1);
  assign next_ph = last_ph ? '0 : phase_q + 1'b1;
  // Priority: en low > (start from IDLE | restart) > skip > hold > tick; a phase end reloads from the table
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sec_d        = sec_q;
    timeout_d    = 1'b0;
    cycle_done_d = 1'b0;
    end_ph       = 1'b0;
    if (!en) begin
      state_d = IDLE;
      phase_d = '0;
      sec_d   = '0;
    end else if (state_q == IDLE || restart) begin
      state_d = RUN;
      phase_d = '0;
      sec_d   = dur_tbl[W-1:0];
    end else if (skip_req) begin
      end_ph = 1'b1;
    end else if (state_q == RUN && hold) begin
      state_d = HOLD;
    end else if (state_q == HOLD) begin
      state_d = hold ? HOLD : RUN;
    end else if (tick) begin
      if (sec_q != '0) sec_d = sec_q - 1'b1;
      else end_ph = 1'b1;
    end
    if (end_ph) begin
      phase_d      = next_ph;
      sec_d        = dur_tbl[next_ph*W +: W];
      timeout_d    = 1'b1;
      cycle_done_d = last_ph;
    end
    running_d = state_d != IDLE;
  end
  // State and registered outputs; reset discards all progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      sec_q        <= '0;
      timeout_q    <= 1'b0;
      cycle_done_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sec_q        <= sec_d;
      timeout_q    <= timeout_d;
      cycle_done_q <= cycle_done_d;
      running_q    <= running_d;
    end
  end
  assign phase      = phase_q;
  assign sec_count  = sec_q;
  assign timeout    = timeout_q;
  assign cycle_done = cycle_done_q;
  assign running    = running_q;
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: table vectors, random run against an elapsed-time model, and hand sequences for hold/reset/skip
module tb_traffic_phase_timer;
  localparam int W = 6, NPH = 4, PW = 2;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, tick = 1'b0, restart = 1'b0, hold = 1'b0;
`ifdef PHASE_SKIP_EN
  logic skip = 1'b0;
`endif
  logic [NPH*W-1:0] dur_tbl;
  logic [PW-1:0] phase;
  logic [W-1:0] sec_count;
  logic timeout, cycle_done, running;
  int checks = 0, errors = 0;
  int m_mode, m_ph, m_len, m_el;
  bit m_to, m_cd;
  typedef struct {
    bit en, tick, restart, hold;
    int ph, sec;
    bit to, cd, run;
  } vec_t;
  vec_t tbl[20];

  always #5 clk = ~clk;

  traffic_phase_timer #(.W(W), .NPH(NPH), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .restart(restart), .hold(hold),
`ifdef PHASE_SKIP_EN
    .skip(skip),
`endif
    .dur_tbl(dur_tbl), .phase(phase), .sec_count(sec_count),
    .timeout(timeout), .cycle_done(cycle_done), .running(running)
  );

  function automatic int dur_of(int k);
    return int'(dur_tbl[k*W +: W]);
  endfunction

  // Model: mode 0 idle / 1 counting / 2 frozen; a phase holds m_len+1 ticks, remaining = m_len - m_el
  task automatic m_start(int k);
    m_ph = k;
    m_len = dur_of(k);
    m_el = 0;
  endtask

  task automatic m_end_phase();
    m_to = 1;
    m_cd = (m_ph == NPH - 1);
    m_start((m_ph + 1) % NPH);
  endtask

  task automatic m_reset();
    m_mode = 0; m_ph = 0; m_len = 0; m_el = 0; m_to = 0; m_cd = 0;
  endtask

  task automatic m_step();
    m_to = 0;
    m_cd = 0;
    if (!en) begin
      m_mode = 0; m_ph = 0; m_len = 0; m_el = 0;
    end else if (m_mode == 0 || restart) begin
      m_mode = 1;
      m_start(0);
    end
`ifdef PHASE_SKIP_EN
    else if (skip) m_end_phase();
`endif
    else if (m_mode == 1 && hold) m_mode = 2;
    else if (m_mode == 2) m_mode = hold ? 2 : 1;
    else if (tick) begin
      if (m_el == m_len) m_end_phase();
      else m_el++;
    end
  endtask

  task automatic chk(string name, int ph, int sec, bit to, bit cd, bit run);
    checks++;
    if (phase !== PW'(ph) || sec_count !== W'(sec) || timeout !== to || cycle_done !== cd || running !== run) begin
      errors++;
      $display("FAIL %s: got ph=%0d sec=%0d to=%0b cd=%0b run=%0b, want ph=%0d sec=%0d to=%0b cd=%0b run=%0b",
               name, phase, sec_count, timeout, cycle_done, running, ph, sec, to, cd, run);
    end
  endtask

  task automatic chk_model(string name);
    chk(name, m_ph, m_len - m_el, m_to, m_cd, m_mode != 0);
  endtask

  task automatic step(bit e, bit t, bit r, bit h);
    @(negedge clk);
    en = e; tick = t; restart = r; hold = h;
    @(posedge clk);
    m_step();
    #1;
  endtask

  initial begin
    dur_tbl = {6'd1, 6'd0, 6'd2, 6'd3};
    m_reset();
    tbl[0]  = '{1,0,0,0, 0,3,0,0,1};
    tbl[1]  = '{1,1,0,0, 0,2,0,0,1};
    tbl[2]  = '{1,1,0,0, 0,1,0,0,1};
    tbl[3]  = '{1,1,0,0, 0,0,0,0,1};
    tbl[4]  = '{1,1,0,0, 1,2,1,0,1};
    tbl[5]  = '{1,0,0,0, 1,2,0,0,1};
    tbl[6]  = '{1,1,0,0, 1,1,0,0,1};
    tbl[7]  = '{1,0,0,1, 1,1,0,0,1};
    tbl[8]  = '{1,1,0,1, 1,1,0,0,1};
    tbl[9]  = '{1,1,0,0, 1,1,0,0,1};
    tbl[10] = '{1,1,0,0, 1,0,0,0,1};
    tbl[11] = '{1,1,0,0, 2,0,1,0,1};
    tbl[12] = '{1,1,0,0, 3,1,1,0,1};
    tbl[13] = '{1,1,0,0, 3,0,0,0,1};
    tbl[14] = '{1,1,0,0, 0,3,1,1,1};
    tbl[15] = '{1,1,1,0, 0,3,0,0,1};
    tbl[16] = '{1,1,0,0, 0,2,0,0,1};
    tbl[17] = '{1,0,1,0, 0,3,0,0,1};
    tbl[18] = '{0,0,0,0, 0,0,0,0,0};
    tbl[19] = '{0,1,0,0, 0,0,0,0,0};
    #12;
    chk("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].tick, tbl[i].restart, tbl[i].hold);
      chk($sformatf("vec%0d", i), tbl[i].ph, tbl[i].sec, tbl[i].to, tbl[i].cd, tbl[i].run);
    end
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0)
        for (int k = 0; k < NPH; k++) dur_tbl[k*W +: W] = W'($urandom_range(0, 3));
`ifdef PHASE_SKIP_EN
      skip = ($urandom_range(0, 19) == 0);
`endif
      step($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0);
      chk_model($sformatf("rand%0d", i));
    end
`ifdef PHASE_SKIP_EN
    skip = 1'b0;
`endif
    dur_tbl = {6'd1, 6'd0, 6'd2, 6'd3};
    step(1, 0, 1, 0);
    chk("restart_load", 0, 3, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    chk("hold_setup", 1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 1);
      chk($sformatf("hold_frozen%0d", i), 1, 1, 0, 0, 1);
    end
    step(1, 0, 0, 0);
    chk("hold_release", 1, 1, 0, 0, 1);
    step(1, 1, 0, 0);
    chk("post_hold_tick", 1, 0, 0, 0, 1);
    step(1, 1, 0, 0);
    chk("post_hold_end", 2, 0, 1, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("mid_phase3", 3, 0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("en_drop", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("pre_reset", 0, 2, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0, 0, 0, 0, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    chk("restart_after_reset", 0, 3, 0, 0, 1);
`ifdef PHASE_SKIP_EN
    step(1, 1, 0, 0);
    chk("skip_setup", 0, 2, 0, 0, 1);
    @(negedge clk);
    skip = 1'b1; tick = 1'b0;
    @(posedge clk);
    m_step();
    #1 chk("skip_end", 1, 2, 1, 0, 1);
    @(negedge clk);
    skip = 1'b0;
    step(1, 0, 0, 0);
    chk("skip_pulse_once", 1, 2, 0, 0, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
